hazard_stall_unit: RTL and testbench

Pipeline hazard controller for the 5-stage 16-bit CPU. The forwarding logic resolves RAW hazards by bypassing EX/MEM and MEM/WB results. This block handles the hazards that bypassing cannot:
- **Load-use:** stall.
- **Unified instruction/data RAM conflict:** structural freeze with a memory handshake and timeout.
- **Taken branch:** flush.

It drives the PC and pipeline-register write enables, tracks memory waits in a small FSM, and keeps a saturating stall-cycle counter.

---
 rtl/hazard_stall_unit.sv | 150 +++++++++++++++
 tb/tb_hazard_stall_unit.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/hazard_stall_unit.sv
// rtl/hazard_stall_unit.sv - load-use stall, unified-RAM freeze/timeout and branch flush control
// Pipeline enables are combinational; state, timeout flag and stall counter are registered.
module hazard_stall_unit #(
  parameter int TIMEOUT = 15,
  parameter int WAIT_W  = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  Rx_ID,
  input  logic [2:0]  Ry_ID,
  input  logic        readRx_ID,
  input  logic        readRy_ID,
  input  logic        readSpecReg_ID,
  input  logic        memRead_IDEX,
  input  logic        regWrite_IDEX,
  input  logic        writeSpecReg_IDEX,
  input  logic [2:0]  registerToWriteId_IDEX,
  input  logic        memAccess_EXMEM,
  input  logic        memReady,
  input  logic        branchTaken_EX,
  output logic        pcWrite,
  output logic        ifidWrite,
  output logic        ifidFlush,
  output logic        idexBubble,
  output logic        pipeFreeze,
  output logic        memReq,
  output logic        memTimeout,
  output logic [1:0]  state,
  output logic [15:0] stallCycles
);

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_ERROR    = 2'd2
  } state_t;

  localparam logic [WAIT_W-1:0] L_TIMEOUT = WAIT_W'(TIMEOUT);

  state_t             r_state;
  logic [WAIT_W-1:0]  r_wait_cnt;
  logic               r_mem_timeout;
  logic [15:0]        r_stall_cycles;

  logic w_src_match;
  logic w_spec_match;
  logic w_load_use;
  logic w_acc;
  logic w_acc_wait;
  logic w_acc_done;

  assign w_src_match  = !writeSpecReg_IDEX &
                        ((readRx_ID & (Rx_ID == registerToWriteId_IDEX)) |
                         (readRy_ID & (Ry_ID == registerToWriteId_IDEX)));
  assign w_spec_match = readSpecReg_ID & writeSpecReg_IDEX;
  assign w_load_use   = memRead_IDEX & regWrite_IDEX & (w_src_match | w_spec_match);

  // Once waiting, the access is considered outstanding whatever EX/MEM now shows.
  assign w_acc      = (r_state == ST_MEM_WAIT) | ((r_state == ST_RUN) & memAccess_EXMEM);
  assign w_acc_wait = w_acc & !memReady;
  assign w_acc_done = w_acc & memReady;

  always_comb begin
    pcWrite    = 1'b1;
    ifidWrite  = 1'b1;
    ifidFlush  = 1'b0;
    idexBubble = 1'b0;
    pipeFreeze = 1'b0;
    memReq     = 1'b0;
    if (rst) begin
      pcWrite    = 1'b0;
      ifidWrite  = 1'b0;
      ifidFlush  = 1'b1;
      idexBubble = 1'b1;
    end else if (r_state == ST_ERROR) begin
      pcWrite    = 1'b0;
      ifidWrite  = 1'b0;
      pipeFreeze = 1'b1;
    end else begin
      memReq = w_acc;
      if (w_acc_wait) begin
        pcWrite    = 1'b0;
        ifidWrite  = 1'b0;
        pipeFreeze = 1'b1;
      end else if (branchTaken_EX) begin
        ifidFlush  = 1'b1;
        idexBubble = 1'b1;
      end else if (w_acc_done && !w_load_use) begin
        // Data access used the RAM port, so the fetched word is lost.
        pcWrite   = 1'b0;
        ifidFlush = 1'b1;
      end else if (w_load_use) begin
        pcWrite    = 1'b0;
        ifidWrite  = 1'b0;
        idexBubble = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= ST_RUN;
      r_wait_cnt    <= '0;
      r_mem_timeout <= 1'b0;
    end else begin
      case (r_state)
        ST_RUN: begin
          if (memAccess_EXMEM && !memReady) begin
            r_state    <= ST_MEM_WAIT;
            r_wait_cnt <= WAIT_W'(1);
          end else begin
            r_wait_cnt <= '0;
          end
        end
        ST_MEM_WAIT: begin
          if (memReady) begin
            r_state    <= ST_RUN;
            r_wait_cnt <= '0;
          end else if (r_wait_cnt == L_TIMEOUT) begin
            r_state       <= ST_ERROR;
            r_mem_timeout <= 1'b1;
          end else begin
            r_wait_cnt <= r_wait_cnt + WAIT_W'(1);
          end
        end
        ST_ERROR: begin
          r_state       <= ST_ERROR;
          r_mem_timeout <= 1'b1;
        end
        default: begin
          r_state    <= ST_RUN;
          r_wait_cnt <= '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stall_cycles <= '0;
    end else if (!pcWrite && (r_stall_cycles != 16'hFFFF)) begin
      r_stall_cycles <= r_stall_cycles + 16'd1;
    end
  end

  assign state       = r_state;
  assign memTimeout  = r_mem_timeout;
  assign stallCycles = r_stall_cycles;

endmodule

// File: tb/tb_hazard_stall_unit.sv
// tb/tb_hazard_stall_unit.sv - scoreboard bench for hazard_stall_unit with directed and random stimulus
module tb_hazard_stall_unit;

  localparam int TIMEOUT = 15;

  typedef struct packed {
    logic [2:0] rx;
    logic [2:0] ry;
    logic       rdx;
    logic       rdy;
    logic       rds;
    logic       mr;
    logic       rw;
    logic       wsr;
    logic [2:0] wid;
    logic       ma;
    logic       ready;
    logic       br;
  } vec_t;

  typedef struct packed {
    logic        pc;
    logic        ifw;
    logic        fl;
    logic        bub;
    logic        frz;
    logic        req;
    logic        to;
    logic [1:0]  st;
    logic [15:0] sc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [2:0]  Rx_ID = '0, Ry_ID = '0, registerToWriteId_IDEX = '0;
  logic        readRx_ID = 0, readRy_ID = 0, readSpecReg_ID = 0;
  logic        memRead_IDEX = 0, regWrite_IDEX = 0, writeSpecReg_IDEX = 0;
  logic        memAccess_EXMEM = 0, memReady = 0, branchTaken_EX = 0;
  logic        pcWrite, ifidWrite, ifidFlush, idexBubble, pipeFreeze, memReq, memTimeout;
  logic [1:0]  state;
  logic [15:0] stallCycles;

  int n_tests = 0;
  int n_fail  = 0;
  int cycle   = 0;

  // Reference model: count of consecutive unanswered access cycles, a dead flag, a stall tally.
  int m_nr     = 0;
  bit m_dead   = 0;
  int m_stalls = 0;

  exp_t exp_q[$];
  int   cyc_q[$];

  always #5 clk = ~clk;

  hazard_stall_unit #(.TIMEOUT(TIMEOUT), .WAIT_W(4)) dut (
    .clk(clk), .rst(rst),
    .Rx_ID(Rx_ID), .Ry_ID(Ry_ID),
    .readRx_ID(readRx_ID), .readRy_ID(readRy_ID), .readSpecReg_ID(readSpecReg_ID),
    .memRead_IDEX(memRead_IDEX), .regWrite_IDEX(regWrite_IDEX),
    .writeSpecReg_IDEX(writeSpecReg_IDEX), .registerToWriteId_IDEX(registerToWriteId_IDEX),
    .memAccess_EXMEM(memAccess_EXMEM), .memReady(memReady), .branchTaken_EX(branchTaken_EX),
    .pcWrite(pcWrite), .ifidWrite(ifidWrite), .ifidFlush(ifidFlush), .idexBubble(idexBubble),
    .pipeFreeze(pipeFreeze), .memReq(memReq), .memTimeout(memTimeout),
    .state(state), .stallCycles(stallCycles)
  );

  task automatic step(input bit r, input vec_t v);
    exp_t e;
    bit   src, spec, lu, acc;
    @(negedge clk);
    cycle++;
    rst = r;
    Rx_ID = v.rx; Ry_ID = v.ry; readRx_ID = v.rdx; readRy_ID = v.rdy; readSpecReg_ID = v.rds;
    memRead_IDEX = v.mr; regWrite_IDEX = v.rw; writeSpecReg_IDEX = v.wsr;
    registerToWriteId_IDEX = v.wid; memAccess_EXMEM = v.ma; memReady = v.ready;
    branchTaken_EX = v.br;
    if (r) begin
      m_nr = 0; m_dead = 0; m_stalls = 0;
    end
    src  = !v.wsr && ((v.rdx && v.rx == v.wid) || (v.rdy && v.ry == v.wid));
    spec = v.rds && v.wsr;
    lu   = v.mr && v.rw && (src || spec);
    acc  = m_dead ? 1'b0 : ((m_nr > 0) ? 1'b1 : v.ma);
    e    = '0;
    e.to = m_dead;
    e.st = m_dead ? 2'd2 : ((m_nr > 0) ? 2'd1 : 2'd0);
    e.sc = m_stalls[15:0];
    if (r) begin
      e.fl = 1; e.bub = 1;
    end else if (m_dead) begin
      e.frz = 1;
    end else begin
      e.req = acc;
      if (acc && !v.ready) e.frz = 1;
      else if (v.br) begin e.pc = 1; e.ifw = 1; e.fl = 1; e.bub = 1; end
      else if (acc && !lu) begin e.ifw = 1; e.fl = 1; end
      else if (lu) e.bub = 1;
      else begin e.pc = 1; e.ifw = 1; end
    end
    exp_q.push_back(e);
    cyc_q.push_back(cycle);
    if (!r) begin
      if (!m_dead) begin
        if (acc && !v.ready) begin
          m_nr++;
          if (m_nr == TIMEOUT + 1) m_dead = 1;
        end else begin
          m_nr = 0;
        end
      end
      if (!e.pc && m_stalls < 65535) m_stalls++;
    end
  endtask

  always begin
    exp_t e, a;
    int   c;
    @(negedge clk);
    #2;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      c = cyc_q.pop_front();
      a = {pcWrite, ifidWrite, ifidFlush, idexBubble, pipeFreeze, memReq, memTimeout, state, stallCycles};
      n_tests++;
      if (a !== e) begin
        n_fail++;
        $display("FAIL outputs cycle %0d: got pc=%b ifw=%b fl=%b bub=%b frz=%b req=%b to=%b st=%0d sc=%0d, expected pc=%b ifw=%b fl=%b bub=%b frz=%b req=%b to=%b st=%0d sc=%0d",
                 c, a.pc, a.ifw, a.fl, a.bub, a.frz, a.req, a.to, a.st, a.sc,
                 e.pc, e.ifw, e.fl, e.bub, e.frz, e.req, e.to, e.st, e.sc);
      end
    end
  end

  function automatic vec_t rand_vec();
    vec_t v;
    v.rx    = 3'($urandom_range(0, 3));
    v.ry    = 3'($urandom_range(0, 3));
    v.wid   = 3'($urandom_range(0, 3));
    v.rdx   = 1'($urandom_range(0, 1));
    v.rdy   = 1'($urandom_range(0, 1));
    v.rds   = ($urandom_range(0, 3) == 0);
    v.mr    = 1'($urandom_range(0, 1));
    v.rw    = ($urandom_range(0, 3) != 0);
    v.wsr   = ($urandom_range(0, 3) == 0);
    v.ma    = ($urandom_range(0, 2) == 0);
    v.ready = ($urandom_range(0, 3) != 0);
    v.br    = ($urandom_range(0, 5) == 0);
    return v;
  endfunction

  initial begin
    vec_t z, v;
    z = '0;
    step(1, z);
    step(1, z);
    step(0, z);

    v = z; v.mr = 1; v.rw = 1; v.wid = 3; v.rx = 3; v.rdx = 1;
    step(0, v);
    step(0, z);
    v.mr = 0; step(0, v);
    v.mr = 1; v.rdx = 0; step(0, v);
    v.rdx = 1; v.br = 1; step(0, v);
    v = z; v.mr = 1; v.rw = 1; v.rds = 1; v.wsr = 1; step(0, v);
    v = z; v.mr = 1; v.rw = 1; v.wsr = 1; v.wid = 2; v.ry = 2; v.rdy = 1; step(0, v);

    v = z; v.ma = 1;
    repeat (3) step(0, v);
    v.ready = 1; step(0, v);
    step(0, z);

    v = z; v.ma = 1; v.br = 1;
    repeat (2) step(0, v);
    v.ready = 1; step(0, v);
    v = z; v.ma = 1; v.ready = 1; v.mr = 1; v.rw = 1; v.rx = 1; v.rdx = 1; v.wid = 1;
    step(0, v);
    v = z; v.ma = 1; v.ready = 1; step(0, v);

    v = z; v.ma = 1;
    repeat (20) step(0, v);
    v.ready = 1; step(0, v);
    step(1, z);
    step(0, z);

    v = z; v.ma = 1;
    repeat (2) step(0, v);
    step(1, v);
    step(0, z);

    for (int i = 0; i < 2000; i++) begin
      step(($urandom_range(0, 63) == 0), rand_vec());
    end

    repeat (3) @(negedge clk);
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expected responses left unchecked, required 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
